// File: rtl/trdb_trigger_unit.sv
// Trace trigger unit: watches retired instructions and turns programmed
// start/stop conditions into the held on/off level requests for the trace register block.
module trdb_trigger_unit #(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 16,
  parameter int HOLD_CYCLES = 2,
  parameter int FIRE_W      = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [1:0]        cfg_mode_i,
  input  logic              cfg_oneshot_i,
  input  logic [XLEN-1:0]   cfg_start_addr_i,
  input  logic [XLEN-1:0]   cfg_stop_addr_i,
  input  logic [CNT_W-1:0]  cfg_count_i,
  input  logic              cfg_disarm_i,
  input  logic              iretire_i,
  input  logic [XLEN-1:0]   iaddr_i,
  output logic              trace_req_on_o,
  output logic              trace_req_off_o,
  output logic [1:0]        state_o,
  output logic [FIRE_W-1:0] fire_count_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_WINDOW = 2'd1;
  localparam logic [1:0] MODE_COUNT  = 2'd2;

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_e             state_reg, state_next;
  logic [1:0]         mode_reg;
  logic               oneshot_reg;
  logic [XLEN-1:0]    start_addr_reg;
  logic [XLEN-1:0]    stop_addr_reg;
  logic [CNT_W-1:0]   count_reg;
  logic [CNT_W-1:0]   remaining_reg, remaining_next;
  logic [FIRE_W-1:0]  fire_count_reg;
  logic [HOLD_W-1:0]  hold_reg;
  logic               on_reg;
  logic               off_reg;

  logic cfg_accept;
  logic on_event;
  logic off_event;
  logic fire_inc;
  logic start_hit;
  logic stop_hit;
  logic cfg_mode_arms;

  assign start_hit     = iretire_i && (iaddr_i == start_addr_reg);
  assign stop_hit      = iretire_i && (iaddr_i == stop_addr_reg);
  assign cfg_mode_arms = (cfg_mode_i == MODE_WINDOW) || (cfg_mode_i == MODE_COUNT);
  assign cfg_ready_o   = ((state_reg == IDLE) || (state_reg == DONE)) && !cfg_disarm_i;

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    cfg_accept     = 1'b0;
    on_event       = 1'b0;
    off_event      = 1'b0;
    fire_inc       = 1'b0;

    if (cfg_disarm_i) begin
      state_next = IDLE;
      off_event  = (state_reg == ACTIVE);
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (cfg_valid_i) begin
            cfg_accept = 1'b1;
            state_next = cfg_mode_arms ? ARMED : IDLE;
          end
        end
        ARMED: begin
          if (start_hit) begin
            on_event       = 1'b1;
            fire_inc       = 1'b1;
            remaining_next = count_reg;
            state_next     = ACTIVE;
          end
        end
        ACTIVE: begin
          // Remaining of 0 or 1 both stop on this retire, so count=0 acts like count=1.
          if (mode_reg == MODE_COUNT && iretire_i) begin
            if (remaining_reg <= CNT_W'(1)) begin
              off_event      = 1'b1;
              remaining_next = '0;
            end else begin
              remaining_next = remaining_reg - CNT_W'(1);
            end
          end else if (mode_reg == MODE_WINDOW && stop_hit) begin
            off_event = 1'b1;
          end
          if (off_event) begin
            state_next = oneshot_reg ? DONE : ARMED;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg      <= IDLE;
      mode_reg       <= MODE_OFF;
      oneshot_reg    <= 1'b0;
      start_addr_reg <= '0;
      stop_addr_reg  <= '0;
      count_reg      <= '0;
      remaining_reg  <= '0;
      fire_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      if (cfg_accept) begin
        mode_reg       <= cfg_mode_arms ? cfg_mode_i : MODE_OFF;
        oneshot_reg    <= cfg_oneshot_i;
        start_addr_reg <= cfg_start_addr_i;
        stop_addr_reg  <= cfg_stop_addr_i;
        count_reg      <= cfg_count_i;
      end
      if (fire_inc && (fire_count_reg != '1)) begin
        fire_count_reg <= fire_count_reg + FIRE_W'(1);
      end
    end
  end

  // A fresh event of either kind takes over the outputs and reloads the hold counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      on_reg   <= 1'b0;
      off_reg  <= 1'b0;
      hold_reg <= '0;
    end else if (on_event) begin
      on_reg   <= 1'b1;
      off_reg  <= 1'b0;
      hold_reg <= HOLD_RELOAD;
    end else if (off_event) begin
      on_reg   <= 1'b0;
      off_reg  <= 1'b1;
      hold_reg <= HOLD_RELOAD;
    end else if (hold_reg != '0) begin
      hold_reg <= hold_reg - HOLD_W'(1);
    end else begin
      on_reg  <= 1'b0;
      off_reg <= 1'b0;
    end
  end

  assign trace_req_on_o  = on_reg;
  assign trace_req_off_o = off_reg;
  assign state_o         = state_reg;
  assign fire_count_o    = fire_count_reg;

endmodule

// File: doc/trdb_trigger_unit.md
Name: trdb_trigger_unit

Overview:
- Trigger unit that generates the trace on/off requests consumed by the trace register block.
- The register block edge-detects both requests, so this block drives them as multi-cycle level pulses.
- Watches the retired-instruction stream (valid + address) and arms/fires on programmed start/stop conditions.
- Configured through a simple valid/ready config port driven by the memory-mapped register file.

Parameters:
XLEN, 32, instruction address width
CNT_W, 16, width of the instruction-count stop counter
HOLD_CYCLES, 2, cycles each request output stays high (>=1)
FIRE_W, 8, width of the saturating start-event counter

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
cfg_valid_i  in  1  config write strobe
cfg_ready_o  out  1  config accepted this cycle when high together with cfg_valid_i
cfg_mode_i  in  2  0=disabled, 1=address window, 2=start address + instruction count, 3=reserved (treated as 0)
cfg_oneshot_i  in  1  1: go to DONE after the first stop; 0: re-arm
cfg_start_addr_i  in  XLEN  start match address
cfg_stop_addr_i  in  XLEN  stop match address (mode 1)
cfg_count_i  in  CNT_W  retires after start before stop (mode 2)
cfg_disarm_i  in  1  abort; return to IDLE from any state
iretire_i  in  1  instruction retired this cycle
iaddr_i  in  XLEN  address of retired instruction
trace_req_on_o  out  1  level request to turn tracing on
trace_req_off_o  out  1  level request to turn tracing off
state_o  out  2  0=IDLE, 1=ARMED, 2=ACTIVE, 3=DONE
fire_count_o  out  FIRE_W  number of start events, saturating

Behaviour:
- Reset: state IDLE; trace_req_on_o=0; trace_req_off_o=0; fire_count_o=0; hold counter=0; stored config=0; cfg_ready_o=1.
- Config is registered only in IDLE or DONE.
  - cfg_ready_o = (state==IDLE || state==DONE) && !cfg_disarm_i.
  - On accept, latch mode/oneshot/addresses/count. Next state is ARMED if mode is 1 or 2, otherwise IDLE.
  - In ARMED/ACTIVE, cfg_valid_i is ignored (no stall, no side effect).
- ARMED: on iretire_i && iaddr_i==start_addr:
  - go ACTIVE next cycle;
  - start an ON pulse;
  - increment fire_count_o (saturates at all-ones);
  - load remaining=cfg_count (mode 2).
  - The start instruction is not checked against stop.
- ACTIVE, mode 1: iretire_i && iaddr_i==stop_addr -> stop event.
- ACTIVE, mode 2: each iretire_i decrements remaining.
  - Stop event on the retire when remaining is 0 or 1 before the decrement.
  - count=0 behaves as count=1 (stop on the first retire after start).
- Stop event: start an OFF pulse. Next state is DONE if oneshot, else ARMED.
  - A start match on the same retire as the stop is ignored.
  - Re-arming becomes effective from the next cycle.
- DONE: holds until cfg_disarm_i or a config accept.
- Pulses:
  - Outputs are registered. A request starting at event cycle t is high on cycles t+1 .. t+HOLD_CYCLES.
  - on and off are never high together.
  - A new pulse of the opposite kind immediately terminates the running pulse and reloads the hold counter.
  - A new event of the same kind during its own pulse reloads the counter (extends the pulse, no glitch low).
- cfg_disarm_i has priority over every other event in that cycle.
  - Next state is IDLE.
  - If the state was ACTIVE, an OFF pulse starts.
  - If the state was ARMED, DONE or IDLE, no pulse starts and any running pulse completes normally.
- Reset mid-pulse: outputs drop asynchronously to 0. There is no pending request after reset.
- Address compare is full XLEN equality. No masking, no ranges.

Test Plan:
1. Reset with rst_i=1 mid-ON-pulse -> both requests drop to 0 immediately; state_o=0, fire_count_o=0.
2. Mode 1, start=0x100, stop=0x200, oneshot=1; retire 0x0FC, 0x100, 0x104, 0x200.
   - trace_req_on_o high 2 cycles after the 0x100 retire.
   - trace_req_off_o high 2 cycles after the 0x200 retire.
   - state_o ends 3; fire_count_o=1.
3. Mode 2, start=0x80, count=3, oneshot=0; retire 0x80 then 3 more.
   - OFF pulse after the 3rd subsequent retire, state back to 1.
   - Repeat: fire_count_o=2.
4. Mode 2, count=1, HOLD_CYCLES=4; retire 0x80 then an immediate retire.
   - ON pulse truncated after 1 cycle; OFF pulse high 4 cycles; the two outputs are never high together.
5. ACTIVE, with stop match and cfg_disarm_i in the same cycle -> exactly one OFF pulse; state_o=0.
   - A subsequent cfg_valid_i with mode=0 is accepted; state_o stays 0.
6. cfg_valid_i in ARMED with new start=0x300 -> ignored; retire 0x300 causes no pulse.
   - Saturation: FIRE_W=2, 5 starts -> fire_count_o=3.
